// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
//   pipe_state_t  : controller state encoding
//   stage_en_t    : per-stage register write enables (pc, if_id, ex_mem, mem_wb)
//   DEFAULT_MAX_WAIT : default watchdog limit in consecutive data-memory busy cycles
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    localparam int DEFAULT_MAX_WAIT = 64;

    localparam stage_en_t STAGE_EN_NONE = '{pc: 1'b0, if_id: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};
    localparam stage_en_t STAGE_EN_ALL  = '{pc: 1'b1, if_id: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};

endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// stall_watchdog: counts consecutive data-memory busy cycles and flags a hung
// memory.
// Ports:
//   clk_i   in  pipeline clock
//   rst_i   in  asynchronous reset, active-low
//   busy    in  a busy cycle that counts toward the limit
//   clear   in  restart the count (takes priority over busy)
//   expire  out this busy cycle is the MAX_WAIT-th consecutive one
module stall_watchdog #(
    parameter int MAX_WAIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy,
    input  logic clear,
    output logic expire
);

    localparam int W = $clog2(MAX_WAIT) + 1;
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT - 1);
    localparam logic [W-1:0] CEIL  = W'(MAX_WAIT);

    logic [W-1:0] wait_cnt;

    // Holds at MAX_WAIT rather than wrapping, so a long busy run can never
    // slip back under the limit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (busy && (wait_cnt < CEIL)) begin
            wait_cnt <= wait_cnt + W'(1);
        end
    end

    // wait_cnt holds the number of earlier busy cycles, so reaching LIMIT
    // while still busy means this is the MAX_WAIT-th one.
    assign expire = busy && (wait_cnt == LIMIT);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: single owner of pipeline freeze policy for the five-stage
// pipeline. Converts hazard and data-memory requests into per-stage write
// enables, IF/ID flush and ID/EX bubble, with start-up sequencing and a
// hung-memory watchdog.
// Parameters:
//   MAX_WAIT  consecutive busy cycles before the watchdog fires
//   CNT_W     stall counter width
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i, load_use_i, dmem_busy_i, branch_taken_i   requests
//   pc_we_o, if_id_we_o, ex_mem_we_o, mem_wb_we_o       stage write enables
//   if_id_flush_o, id_ex_bubble_o                       NOP insertion
//   err_o                                               sticky watchdog error
//   stall_cnt_o                                         stall-cycle count
// Build option: PIPE_STALL_CNT_EN enables the saturating stall counter;
// without it stall_cnt_o is tied to zero.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | frozen, waiting for start_i
// ST_RUN      | normal flow, enables decoded from hazard requests
// ST_MEM_WAIT | frozen on a multi-cycle data-memory access
// ST_ERROR    | watchdog fired, frozen until reset
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_i,
    input  logic             dmem_busy_i,
    input  logic             branch_taken_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_we_o,
    output logic             mem_wb_we_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    pipe_state_t state, state_nxt;
    stage_en_t   en;
    logic        flush;
    logic        bubble;
    logic        wd_busy;
    logic        wd_expire;

    // A RUN cycle with start_i low is treated as idle and does not count.
    assign wd_busy = dmem_busy_i &&
                     (((state == ST_RUN) && start_i) || (state == ST_MEM_WAIT));

    stall_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .busy   (wd_busy),
        .clear  (!wd_busy),
        .expire (wd_expire)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        en        = STAGE_EN_NONE;
        flush     = 1'b0;
        bubble    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!start_i) begin
                    state_nxt = ST_IDLE;
                end else if (dmem_busy_i) begin
                    state_nxt = wd_expire ? ST_ERROR : ST_MEM_WAIT;
                end else if (load_use_i) begin
                    // ID is held and re-evaluated next cycle, so a
                    // simultaneous taken branch is deliberately dropped.
                    en     = '{pc: 1'b0, if_id: 1'b0, ex_mem: 1'b1, mem_wb: 1'b1};
                    bubble = 1'b1;
                end else begin
                    en    = STAGE_EN_ALL;
                    flush = branch_taken_i;
                end
            end

            ST_MEM_WAIT: begin
                if (dmem_busy_i) begin
                    if (wd_expire) begin
                        state_nxt = ST_ERROR;
                    end
                end else begin
                    // Completing access: release in the same cycle with the
                    // normal decode so no cycle is lost.
                    state_nxt = ST_RUN;
                    if (load_use_i) begin
                        en     = '{pc: 1'b0, if_id: 1'b0, ex_mem: 1'b1, mem_wb: 1'b1};
                        bubble = 1'b1;
                    end else begin
                        en    = STAGE_EN_ALL;
                        flush = branch_taken_i;
                    end
                end
            end

            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pc_we_o        = en.pc;
    assign if_id_we_o     = en.if_id;
    assign ex_mem_we_o    = en.ex_mem;
    assign mem_wb_we_o    = en.mem_wb;
    assign if_id_flush_o  = flush;
    assign id_ex_bubble_o = bubble;
    assign err_o          = (state == ST_ERROR);

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (((state == ST_RUN) || (state == ST_MEM_WAIT)) && !en.pc &&
                     (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
